mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Combined memory-access and write-back stage of the 16-bit pipelined CPU. It accepts an executed instruction, performs an optional data-memory load or store over a request/acknowledge bus, and drives the register write-back port (`writeBackReg`, `writeBackData`, plus an enable) that the decode stage's register file consumes. It stalls upstream for the duration of a memory access and aborts accesses that exceed a timeout.

## Interface
- `TIMEOUT`, 15: maximum number of cycles with `mem_req` high and no `mem_ack` before the access is aborted (range 1..255).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  the upstream instruction is valid this cycle.
- `aluResult`  in  16  ALU output; used as the memory address or as the write-back value.
- `storeData`  in  16  data written to memory on a store.
- `controlMem`  in  2  00 none, 01 load, 10 store, 11 reserved (treated as 00).
- `memToReg`  in  1  write back load data instead of `aluResult`; honoured only when `controlMem`=01.
- `writeReg`  in  4  destination register; 4'hF means no destination.
- `stall`  out  1  upstream must hold its outputs stable while this is high.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = store, 0 = load.
- `mem_addr`  out  16  access address.
- `mem_wdata`  out  16  store data.
- `mem_ack`  in  1  access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  load data.
- `writeBackEn`  out  1  one-cycle pulse: write `writeBackData` to `writeBackReg`.
- `writeBackReg`  out  4  write-back register index.
- `writeBackData`  out  16  write-back value.
- `bus_err`  out  1  sticky flag; set when an access times out.

## Operation
- FSM states: IDLE and ACCESS. Reset state is IDLE.
- **IDLE, no memory operation.** When `in_valid` is high and `controlMem` is 00 or 11, the stage registers `writeBackReg`=`writeReg` and `writeBackData`=`aluResult`. It pulses `writeBackEn` next cycle only if `writeReg`≠4'hF. State stays IDLE.
- **IDLE, memory operation.** When `in_valid` is high and `controlMem` is 01 or 10, the stage latches address, store data, type, `memToReg` and `writeReg`, then goes to ACCESS.
- **ACCESS.**
  - `mem_req`=1. `mem_we`, `mem_addr` and `mem_wdata` come from the latched values and are held stable.
  - The timeout counter clears on entry and increments each cycle without `mem_ack`.
- **ACCESS, `mem_ack`=1.** Return to IDLE and register the write-back:
  - Data = `mem_rdata` for a load with `memToReg`=1, otherwise the latched `aluResult`.
  - `writeBackEn` pulses if the latched `writeReg`≠4'hF.
- **ACCESS, timeout.** On the TIMEOUT-th consecutive cycle without ack, return to IDLE and set `bus_err`. No write-back occurs for the aborted instruction. If `mem_ack` arrives in that same cycle, the ack wins and there is no error.
- `stall` = (state == ACCESS), driven combinationally from the state register.
- `in_valid` is ignored in ACCESS. Upstream holds the next instruction, which is accepted in the first IDLE cycle after the access.
- `writeBackReg` and `writeBackData` hold their last values between pulses. `writeBackEn` is never high for two cycles from the same instruction.
- `bus_err` is cleared only by reset.

## Timing
- Reset values:
  - `stall`, `mem_req`, `mem_we`, `writeBackEn`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `writeBackData` = 16'h0000.
  - `writeBackReg` = 4'h0.
- Non-memory instruction: accepted in cycle N; `writeBackEn` is high in cycle N+1. Throughput is one per cycle.
- Memory instruction accepted in cycle N:
  - `mem_req` and `stall` rise in N+1.
  - If `mem_ack` arrives in cycle M ≥ N+1, then in cycle M+1: `mem_req` and `stall` are low and the `writeBackEn` pulse is present.
  - Minimum total is 2 cycles from acceptance to write-back.
- Timeout: with no ack, `mem_req` is high for exactly TIMEOUT cycles (N+1..N+TIMEOUT). `bus_err` goes high in N+TIMEOUT+1.
- `mem_ack` outside ACCESS is ignored.
- Reset asserted during ACCESS: at that edge, `mem_req` drops, the pending access is discarded and no write-back is issued.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles with random inputs -> every output at its reset value. `writeBackEn` stays 0 for one idle cycle after reset is released.
- **Back-to-back ALU ops.** Send R3←16'h1234, then R5←16'hABCD, then `writeReg`=4'hF -> `writeBackEn` pulses in consecutive cycles with (3,1234) and (5,ABCD), no pulse for the third op, and `stall` stays 0.
- **Load with 3-cycle ack delay.** Load addr 16'h8000, `memToReg`=1, `writeReg`=2; ack in the 3rd `mem_req` cycle with `mem_rdata`=16'h55AA -> `mem_we`=0 and addr held for 3 cycles, `stall` high for 3 cycles, then write-back (2, 55AA). The next instruction, held during the stall, is accepted afterwards.
- **Store with same-cycle ack.** Store addr 16'h0010, data 16'hBEEF, `writeReg`=F; ack in the first `mem_req` cycle -> `mem_we`=1, `mem_wdata`=BEEF for one cycle, no write-back.
- **Timeout.** With TIMEOUT=4, a load receives no ack -> `mem_req` is high for exactly 4 cycles, then `bus_err`=1 sticky, no write-back. A following ALU op completes normally. Repeat with ack in the 4th cycle -> no error and normal write-back.
- **Reset mid-access.** Assert `rst` during the 2nd `mem_req` cycle of a load -> `mem_req` is 0 after that edge and no `writeBackEn` pulse occurs.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: optional load/store over a req/ack bus,
// register write-back pulse, upstream stall and access timeout.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] aluResult,
  input  logic [15:0] storeData,
  input  logic [1:0]  controlMem,
  input  logic        memToReg,
  input  logic [3:0]  writeReg,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        writeBackEn,
  output logic [3:0]  writeBackReg,
  output logic [15:0] writeBackData,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] NO_REG   = 4'hF;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        m2r_q, m2r_d;
  logic [3:0]  wreg_q, wreg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_reg_q, wb_reg_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic        is_mem_s;

  // Reserved encoding 11 falls through to "no memory operation".
  assign is_mem_s = (controlMem == 2'b01) || (controlMem == 2'b10);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m2r_d     = m2r_q;
    wreg_d    = wreg_q;
    cnt_d     = cnt_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && is_mem_s) begin
          we_d    = (controlMem == 2'b10);
          addr_d  = aluResult;
          wdata_d = storeData;
          m2r_d   = memToReg && (controlMem == 2'b01);
          wreg_d  = writeReg;
          cnt_d   = 8'd0;
          state_d = ACCESS;
        end else if (in_valid) begin
          wb_reg_d  = writeReg;
          wb_data_d = aluResult;
          wb_en_d   = (writeReg != NO_REG);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // An ack in the final timeout cycle still completes the access.
        if (mem_ack) begin
          wb_reg_d  = wreg_q;
          wb_data_d = m2r_q ? mem_rdata : addr_q;
          wb_en_d   = (wreg_q != NO_REG);
          state_d   = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      m2r_q     <= 1'b0;
      wreg_q    <= 4'h0;
      cnt_q     <= 8'd0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= 4'h0;
      wb_data_q <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m2r_q     <= m2r_d;
      wreg_q    <= wreg_d;
      cnt_q     <= cnt_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign stall         = (state_q == ACCESS);
  assign mem_req       = (state_q == ACCESS);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign writeBackEn   = wb_en_q;
  assign writeBackReg  = wb_reg_q;
  assign writeBackData = wb_data_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with TIMEOUT=4; expected values hand-computed.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] aluResult;
  logic [15:0] storeData;
  logic [1:0]  controlMem;
  logic        memToReg;
  logic [3:0]  writeReg;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        writeBackEn;
  logic [3:0]  writeBackReg;
  logic [15:0] writeBackData;
  logic        bus_err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluResult(aluResult),
    .storeData(storeData), .controlMem(controlMem), .memToReg(memToReg),
    .writeReg(writeReg), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .writeBackEn(writeBackEn),
    .writeBackReg(writeBackReg), .writeBackData(writeBackData),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] cm, input logic m2r, input logic [3:0] wr,
                       input logic [15:0] alu, input logic [15:0] sd);
    in_valid   = 1'b1;
    controlMem = cm;
    memToReg   = m2r;
    writeReg   = wr;
    aluResult  = alu;
    storeData  = sd;
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [3:0] r, input logic [15:0] d);
    check_val({tag, ".en"}, 32'(writeBackEn), 32'(en));
    if (en) begin
      check_val({tag, ".reg"}, 32'(writeBackReg), 32'(r));
      check_val({tag, ".data"}, 32'(writeBackData), 32'(d));
    end
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b0;
    in_valid = 1'($urandom); aluResult = 16'($urandom); storeData = 16'($urandom);
    controlMem = 2'($urandom); memToReg = 1'($urandom); writeReg = 4'($urandom);
    mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
    tick(); tick();
    check_val("rst.stall", 32'(stall), 32'd0);
    check_val("rst.req", 32'(mem_req), 32'd0);
    check_val("rst.we", 32'(mem_we), 32'd0);
    check_val("rst.addr", 32'(mem_addr), 32'h0);
    check_val("rst.wdata", 32'(mem_wdata), 32'h0);
    check_val("rst.wben", 32'(writeBackEn), 32'd0);
    check_val("rst.wbreg", 32'(writeBackReg), 32'h0);
    check_val("rst.wbdata", 32'(writeBackData), 32'h0);
    check_val("rst.err", 32'(bus_err), 32'd0);
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0;
    tick();
    check_val("post_rst.wben", 32'(writeBackEn), 32'd0);

    // Back-to-back ALU ops
    issue(2'b00, 1'b0, 4'h3, 16'h1234, 16'h0000);
    tick();
    check_wb("alu1", 1'b1, 4'h3, 16'h1234);
    check_val("alu1.stall", 32'(stall), 32'd0);
    issue(2'b11, 1'b1, 4'h5, 16'hABCD, 16'h0000);
    tick();
    check_wb("alu2", 1'b1, 4'h5, 16'hABCD);
    check_val("alu2.stall", 32'(stall), 32'd0);
    issue(2'b00, 1'b0, 4'hF, 16'h0777, 16'h0000);
    tick();
    check_wb("alu3", 1'b0, 4'h0, 16'h0);
    check_val("alu3.stall", 32'(stall), 32'd0);
    in_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    check_val("idle_ack.wben", 32'(writeBackEn), 32'd0);
    check_val("idle_ack.req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // Load with ack in 3rd request cycle; next instruction held during stall
    issue(2'b01, 1'b1, 4'h2, 16'h8000, 16'h1111);
    tick();
    issue(2'b00, 1'b0, 4'h7, 16'h0042, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("ld.req%0d", i), 32'(mem_req), 32'd1);
      check_val($sformatf("ld.stall%0d", i), 32'(stall), 32'd1);
      check_val($sformatf("ld.we%0d", i), 32'(mem_we), 32'd0);
      check_val($sformatf("ld.addr%0d", i), 32'(mem_addr), 32'h8000);
      check_val($sformatf("ld.wben%0d", i), 32'(writeBackEn), 32'd0);
      if (i == 2) begin
        mem_ack = 1'b1;
        mem_rdata = 16'h55AA;
      end else begin
        mem_ack = 1'b0;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check_val("ld.done_req", 32'(mem_req), 32'd0);
    check_val("ld.done_stall", 32'(stall), 32'd0);
    check_wb("ld.wb", 1'b1, 4'h2, 16'h55AA);
    tick();
    in_valid = 1'b0;
    check_wb("held.wb", 1'b1, 4'h7, 16'h0042);
    tick();
    check_val("held.once", 32'(writeBackEn), 32'd0);

    // Store with same-cycle ack
    issue(2'b10, 1'b0, 4'hF, 16'h0010, 16'hBEEF);
    tick();
    in_valid = 1'b0;
    mem_ack = 1'b1;
    check_val("st.req", 32'(mem_req), 32'd1);
    check_val("st.we", 32'(mem_we), 32'd1);
    check_val("st.addr", 32'(mem_addr), 32'h0010);
    check_val("st.wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    mem_ack = 1'b0;
    check_val("st.req_off", 32'(mem_req), 32'd0);
    check_val("st.wben", 32'(writeBackEn), 32'd0);
    check_val("st.err", 32'(bus_err), 32'd0);

    // Ack in the TIMEOUT-th cycle wins; memToReg=0 writes back the address value
    issue(2'b01, 1'b0, 4'h9, 16'h2222, 16'h0000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("late.req%0d", i), 32'(mem_req), 32'd1);
      mem_ack = (i == 3);
      mem_rdata = 16'hDEAD;
      tick();
    end
    mem_ack = 1'b0;
    check_val("late.req_off", 32'(mem_req), 32'd0);
    check_val("late.err", 32'(bus_err), 32'd0);
    check_wb("late.wb", 1'b1, 4'h9, 16'h2222);

    // Timeout: no ack
    issue(2'b01, 1'b1, 4'h4, 16'h1000, 16'h0000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("to.req%0d", i), 32'(mem_req), 32'd1);
      check_val($sformatf("to.err%0d", i), 32'(bus_err), 32'd0);
      tick();
    end
    check_val("to.req_off", 32'(mem_req), 32'd0);
    check_val("to.stall_off", 32'(stall), 32'd0);
    check_val("to.err", 32'(bus_err), 32'd1);
    check_val("to.wben", 32'(writeBackEn), 32'd0);
    issue(2'b00, 1'b0, 4'h6, 16'h0606, 16'h0000);
    tick();
    in_valid = 1'b0;
    check_wb("to.alu", 1'b1, 4'h6, 16'h0606);
    check_val("to.sticky", 32'(bus_err), 32'd1);

    // Reset in the 2nd request cycle of a load
    issue(2'b01, 1'b1, 4'hA, 16'h3000, 16'h0000);
    tick();
    in_valid = 1'b0;
    check_val("rma.req1", 32'(mem_req), 32'd1);
    tick();
    check_val("rma.req2", 32'(mem_req), 32'd1);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    check_val("rma.req_off", 32'(mem_req), 32'd0);
    check_val("rma.wben", 32'(writeBackEn), 32'd0);
    check_val("rma.err_clr", 32'(bus_err), 32'd0);
    rst = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val($sformatf("rma.quiet%0d", i), 32'(writeBackEn), 32'd0);
      check_val($sformatf("rma.idle%0d", i), 32'(mem_req), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
